// File: rtl/pps_pkg.sv
// Shared 1PPS definitions: FSM states, cycle-count type and default period,
// used by the phase meter and the local divider.
package pps_pkg;

  typedef enum logic [1:0] {
    PPS_IDLE,
    PPS_ACQ,
    PPS_RUN,
    PPS_HOLDOVER
  } pps_state_t;

  typedef logic signed [24:0] pps_cnt_t;
  typedef logic signed [25:0] pps_wide_t;

  localparam int unsigned PPS_PERIOD_DEFAULT = 10_000_000;

  // Symmetric clamp of a wide intermediate into the 25-bit output range.
  function automatic pps_cnt_t pps_sat(input pps_wide_t v, input int unsigned lim);
    pps_wide_t hi;
    pps_wide_t lo;
    hi = pps_wide_t'(lim);
    lo = -hi;
    if (v > hi)      return pps_cnt_t'(hi);
    else if (v < lo) return pps_cnt_t'(lo);
    else             return pps_cnt_t'(v);
  endfunction

endpackage

// File: rtl/pps_edge_sync.sv
// Two-flop synchronizer followed by a single-cycle rising-edge detector.
module pps_edge_sync (
  input  logic CLK_SYS,
  input  logic CLK_RST,
  input  logic din,
  output logic rise
);

  logic [2:0] sr;

  always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) sr <= '0;
    else          sr <= {sr[1:0], din};
  end

  assign rise = sr[1] & ~sr[2];

endmodule

// File: rtl/pps_phase_meas.sv
// GPS 1PPS interval and local-vs-GPS phase meter with holdover detection.
// Build macro PPS_PHASE_CORR_EN: compensate = sat(period_err - phase_err) instead of sat(period_err).
module pps_phase_meas
  import pps_pkg::*;
#(
  parameter int unsigned PERIOD   = PPS_PERIOD_DEFAULT,
  parameter int unsigned TIMEOUT  = 12_000_000,
  parameter int unsigned MAX_DEV  = 1000,
  parameter int unsigned COMP_MAX = 5000
) (
  input  logic               CLK_SYS,
  input  logic               CLK_RST,
  input  logic               _1PPS_GPS,
  input  logic               _1PPS_Local,
  input  logic               enable,
  output logic signed [24:0] period_err,
  output logic signed [24:0] phase_err,
  output logic signed [24:0] compensate,
  output logic               meas_valid,
  output logic               meas_reject,
  output logic               gps_lost
);

  localparam pps_wide_t PERIOD_W = pps_wide_t'(PERIOD);
  localparam pps_wide_t HALF_W   = pps_wide_t'(PERIOD / 2);
  localparam pps_wide_t MAXDEV_W = pps_wide_t'(MAX_DEV);
  localparam pps_cnt_t  TOUT_C   = pps_cnt_t'(TIMEOUT - 1);

  logic gps_rise;
  logic local_rise;

  // The local pulse takes the same synchronizer path so equal pin timing lines up.
  pps_edge_sync u_gps_sync (
    .CLK_SYS (CLK_SYS),
    .CLK_RST (CLK_RST),
    .din     (_1PPS_GPS),
    .rise    (gps_rise)
  );

  pps_edge_sync u_local_sync (
    .CLK_SYS (CLK_SYS),
    .CLK_RST (CLK_RST),
    .din     (_1PPS_Local),
    .rise    (local_rise)
  );

  pps_state_t state, state_nxt;
  pps_cnt_t   count, count_nxt;
  pps_cnt_t   cap, cap_nxt;
  logic       seen, seen_nxt;
  pps_cnt_t   pe_nxt, ph_nxt, comp_nxt;
  logic       valid_nxt, reject_nxt, lost_nxt;

  pps_wide_t elapsed;
  pps_wide_t local_c;
  pps_wide_t local_cap_w;
  pps_wide_t dev;
  pps_wide_t corr;
  pps_cnt_t  local_cap;
  pps_cnt_t  ph_new;
  logic      in_range;
  logic      timeout;

  // elapsed = cycles since the opening GPS edge; a coincident local edge counts as 0.
  assign elapsed     = pps_wide_t'(count) + 26'sd1;
  assign local_c     = gps_rise ? '0 : elapsed;
  assign local_cap_w = (local_c < HALF_W) ? local_c : local_c - PERIOD_W;
  assign local_cap   = pps_cnt_t'(local_cap_w);
  assign ph_new      = local_rise ? local_cap : (seen ? cap : phase_err);
  assign dev         = elapsed - PERIOD_W;
  assign in_range    = (dev <= MAXDEV_W) && (dev >= -MAXDEV_W);
  assign timeout     = (count == TOUT_C);

`ifdef PPS_PHASE_CORR_EN
  assign corr = dev - pps_wide_t'(ph_new);
`else
  assign corr = dev;
`endif

  always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) state <= PPS_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    seen_nxt   = seen;
    cap_nxt    = cap;
    pe_nxt     = period_err;
    ph_nxt     = phase_err;
    comp_nxt   = compensate;
    valid_nxt  = 1'b0;
    reject_nxt = 1'b0;
    lost_nxt   = gps_lost;

    if (!enable) begin
      state_nxt = PPS_IDLE;
      count_nxt = '0;
      seen_nxt  = 1'b0;
      lost_nxt  = 1'b0;
    end else begin
      if (local_rise && (state == PPS_ACQ || state == PPS_RUN)) begin
        seen_nxt = 1'b1;
        cap_nxt  = local_cap;
      end
      case (state)
        PPS_IDLE: begin
          count_nxt = '0;
          seen_nxt  = 1'b0;
          if (gps_rise) state_nxt = PPS_ACQ;
        end
        PPS_ACQ: begin
          if (gps_rise) begin
            state_nxt = PPS_RUN;
            count_nxt = '0;
            seen_nxt  = 1'b0;
          end else if (timeout) begin
            state_nxt = PPS_HOLDOVER;
            lost_nxt  = 1'b1;
            count_nxt = '0;
            seen_nxt  = 1'b0;
          end else begin
            count_nxt = count + 25'sd1;
          end
        end
        PPS_RUN: begin
          if (gps_rise) begin
            count_nxt = '0;
            seen_nxt  = 1'b0;
            if (in_range) begin
              pe_nxt    = pps_cnt_t'(dev);
              ph_nxt    = ph_new;
              comp_nxt  = pps_sat(corr, COMP_MAX);
              valid_nxt = 1'b1;
            end else begin
              reject_nxt = 1'b1;
            end
          end else if (timeout) begin
            state_nxt = PPS_HOLDOVER;
            lost_nxt  = 1'b1;
            count_nxt = '0;
            seen_nxt  = 1'b0;
          end else begin
            count_nxt = count + 25'sd1;
          end
        end
        PPS_HOLDOVER: begin
          count_nxt = '0;
          seen_nxt  = 1'b0;
          if (gps_rise) begin
            state_nxt = PPS_ACQ;
            lost_nxt  = 1'b0;
          end
        end
        default: state_nxt = PPS_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) begin
      count       <= '0;
      cap         <= '0;
      seen        <= 1'b0;
      period_err  <= '0;
      phase_err   <= '0;
      compensate  <= '0;
      meas_valid  <= 1'b0;
      meas_reject <= 1'b0;
      gps_lost    <= 1'b0;
    end else begin
      count       <= count_nxt;
      cap         <= cap_nxt;
      seen        <= seen_nxt;
      period_err  <= pe_nxt;
      phase_err   <= ph_nxt;
      compensate  <= comp_nxt;
      meas_valid  <= valid_nxt;
      meas_reject <= reject_nxt;
      gps_lost    <= lost_nxt;
    end
  end

endmodule

// File: tb/tb_pps_phase_meas.sv
// Self-checking bench for pps_phase_meas: pin-level event schedules scored against an interval model.
module tb_pps_phase_meas;

  localparam int P  = 1000;
  localparam int TO = 1200;
  localparam int MD = 50;
  localparam int CM = 40;
  localparam int W  = 10;
`ifdef PPS_PHASE_CORR_EN
  localparam bit CORR = 1'b1;
`else
  localparam bit CORR = 1'b0;
`endif

  logic CLK_SYS = 1'b0;
  logic CLK_RST = 1'b0;
  logic gps = 1'b0;
  logic loc = 1'b0;
  logic enable = 1'b0;
  logic signed [24:0] period_err, phase_err, compensate;
  logic meas_valid, meas_reject, gps_lost;

  int total = 0;
  int bad = 0;

  int sg[$];
  int sl[$];
  int ek[$], epe[$], eph[$], ecomp[$], elost[$];
  int mk[$], mpe[$], mph[$], mcomp[$];
  int lost_t;
  int xpe = 0, xph = 0, xcomp = 0;

  pps_phase_meas #(.PERIOD(P), .TIMEOUT(TO), .MAX_DEV(MD), .COMP_MAX(CM)) dut (
    .CLK_SYS     (CLK_SYS),
    .CLK_RST     (CLK_RST),
    ._1PPS_GPS   (gps),
    ._1PPS_Local (loc),
    .enable      (enable),
    .period_err  (period_err),
    .phase_err   (phase_err),
    .compensate  (compensate),
    .meas_valid  (meas_valid),
    .meas_reject (meas_reject),
    .gps_lost    (gps_lost)
  );

  always #5 CLK_SYS = ~CLK_SYS;

  function automatic logic in_pulse(input int q[$], input int t);
    foreach (q[i]) if (t >= q[i] && t < q[i] + W) return 1'b1;
    return 1'b0;
  endfunction

  // Drives the schedules for n cycles and logs every strobe with the outputs seen with it.
  task automatic play(input int n);
    logic prev_lost;
    ek.delete(); epe.delete(); eph.delete(); ecomp.delete(); elost.delete();
    lost_t = -1;
    prev_lost = gps_lost;
    for (int t = 0; t < n; t++) begin
      @(negedge CLK_SYS);
      if (meas_valid || meas_reject) begin
        ek.push_back((meas_valid && meas_reject) ? 3 : (meas_valid ? 1 : 2));
        epe.push_back(int'(period_err));
        eph.push_back(int'(phase_err));
        ecomp.push_back(int'(compensate));
        elost.push_back(int'(gps_lost));
      end
      if (gps_lost && !prev_lost && lost_t < 0) lost_t = t;
      prev_lost = gps_lost;
      gps = in_pulse(sg, t);
      loc = in_pulse(sl, t);
    end
  endtask

  // Interval-level reference: first edge acquires, second opens, later edges close intervals.
  task automatic model();
    int st, len, dev, s, c, corr;
    mk.delete(); mpe.delete(); mph.delete(); mcomp.delete();
    st = 0;
    for (int k = 0; k < sg.size(); k++) begin
      if (k > 0 && st != 0 && sg[k] - sg[k-1] > TO) st = 0;
      if (st < 2) st++;
      else begin
        len = sg[k] - sg[k-1];
        dev = len - P;
        s = -1;
        foreach (sl[i]) if (sl[i] > sg[k-1] && sl[i] <= sg[k] && sl[i] > s) s = sl[i];
        if (dev >= -MD && dev <= MD) begin
          if (s >= 0) begin
            c = (s == sg[k]) ? 0 : s - sg[k-1];
            xph = (c < P / 2) ? c : c - P;
          end
          xpe = dev;
          corr = CORR ? dev - xph : dev;
          xcomp = (corr > CM) ? CM : ((corr < -CM) ? -CM : corr);
          mk.push_back(1);
        end else begin
          mk.push_back(2);
        end
        mpe.push_back(xpe); mph.push_back(xph); mcomp.push_back(xcomp);
      end
    end
  endtask

  task automatic to_idle();
    gps = 1'b0; loc = 1'b0; enable = 1'b0;
    repeat (4) @(negedge CLK_SYS);
    enable = 1'b1;
  endtask

  task automatic test_reset();
    CLK_RST = 1'b0; enable = 1'b0;
    repeat (5) @(negedge CLK_SYS);
    total++; if (period_err !== 25'sd0) begin bad++; $display("FAIL rst_pe got=%0d exp=0", period_err); end
    total++; if (phase_err !== 25'sd0) begin bad++; $display("FAIL rst_ph got=%0d exp=0", phase_err); end
    total++; if (compensate !== 25'sd0) begin bad++; $display("FAIL rst_comp got=%0d exp=0", compensate); end
    total++; if (meas_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", meas_valid); end
    total++; if (meas_reject !== 1'b0) begin bad++; $display("FAIL rst_reject got=%b exp=0", meas_reject); end
    total++; if (gps_lost !== 1'b0) begin bad++; $display("FAIL rst_lost got=%b exp=0", gps_lost); end
    CLK_RST = 1'b1;
    xpe = 0; xph = 0; xcomp = 0;
  endtask

  task automatic test_coincident();
    int b;
    b = 10 + $urandom_range(0, 20);
    sg.delete(); sl.delete();
    for (int k = 0; k < 5; k++) begin sg.push_back(b + k * 1003); sl.push_back(b + k * 1003); end
    to_idle(); play(sg[$] + 20); model();
    total++; if (ek.size() !== mk.size()) begin bad++; $display("FAIL coinc_count got=%0d exp=%0d", ek.size(), mk.size()); end
    for (int i = 0; i < mk.size() && i < ek.size(); i++) begin
      total++;
      if (ek[i] !== mk[i] || epe[i] !== mpe[i] || eph[i] !== mph[i] || ecomp[i] !== mcomp[i]) begin
        bad++; $display("FAIL coinc_ev%0d got k=%0d pe=%0d ph=%0d comp=%0d exp k=%0d pe=%0d ph=%0d comp=%0d",
                        i, ek[i], epe[i], eph[i], ecomp[i], mk[i], mpe[i], mph[i], mcomp[i]);
      end
    end
  endtask

  task automatic test_lag_lead(input int off);
    int b;
    b = 20 + $urandom_range(0, 20);
    sg.delete(); sl.delete();
    for (int k = 0; k < 5; k++) begin sg.push_back(b + k * P); sl.push_back(b + k * P + off); end
    to_idle(); play(sg[$] + 20); model();
    total++; if (ek.size() !== mk.size()) begin bad++; $display("FAIL lag%0d_count got=%0d exp=%0d", off, ek.size(), mk.size()); end
    for (int i = 0; i < mk.size() && i < ek.size(); i++) begin
      total++;
      if (ek[i] !== mk[i] || epe[i] !== mpe[i] || eph[i] !== mph[i] || ecomp[i] !== mcomp[i]) begin
        bad++; $display("FAIL lag%0d_ev%0d got k=%0d pe=%0d ph=%0d comp=%0d exp k=%0d pe=%0d ph=%0d comp=%0d",
                        off, i, ek[i], epe[i], eph[i], ecomp[i], mk[i], mpe[i], mph[i], mcomp[i]);
      end
    end
  endtask

  task automatic test_reject();
    int d[7];
    int g;
    d = '{1000, 1000, 1050, 949, 950, 900, 1000};
    sg.delete(); sl.delete();
    g = 15;
    sg.push_back(g);
    foreach (d[i]) begin
      sl.push_back(g + int'($urandom_range(1, 400)));
      g += d[i];
      sg.push_back(g);
    end
    to_idle(); play(sg[$] + 20); model();
    total++; if (ek.size() !== mk.size()) begin bad++; $display("FAIL rej_count got=%0d exp=%0d", ek.size(), mk.size()); end
    for (int i = 0; i < mk.size() && i < ek.size(); i++) begin
      total++;
      if (ek[i] !== mk[i] || epe[i] !== mpe[i] || eph[i] !== mph[i] || ecomp[i] !== mcomp[i]) begin
        bad++; $display("FAIL rej_ev%0d got k=%0d pe=%0d ph=%0d comp=%0d exp k=%0d pe=%0d ph=%0d comp=%0d",
                        i, ek[i], epe[i], eph[i], ecomp[i], mk[i], mpe[i], mph[i], mcomp[i]);
      end
    end
  endtask

  task automatic test_random();
    int g, off;
    sg.delete(); sl.delete();
    g = 450;
    for (int k = 0; k < 12; k++) begin
      sg.push_back(g);
      if ($urandom_range(0, 9) < 8) begin
        off = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 800)) - 400;
        sl.push_back(g + off);
      end
      g += int'($urandom_range(860, 1140));
    end
    to_idle(); play(sg[$] + 420); model();
    total++; if (ek.size() !== mk.size()) begin bad++; $display("FAIL rnd_count got=%0d exp=%0d", ek.size(), mk.size()); end
    for (int i = 0; i < mk.size() && i < ek.size(); i++) begin
      total++;
      if (ek[i] !== mk[i] || epe[i] !== mpe[i] || eph[i] !== mph[i] || ecomp[i] !== mcomp[i]) begin
        bad++; $display("FAIL rnd_ev%0d got k=%0d pe=%0d ph=%0d comp=%0d exp k=%0d pe=%0d ph=%0d comp=%0d",
                        i, ek[i], epe[i], eph[i], ecomp[i], mk[i], mpe[i], mph[i], mcomp[i]);
      end
    end
  endtask

  task automatic test_holdover();
    sg.delete(); sl.delete();
    for (int k = 0; k < 4; k++) begin sg.push_back(10 + k * P); sl.push_back(10 + k * P + 12); end
    to_idle(); play(sg[$] + TO + 30); model();
    total++; if (ek.size() !== mk.size()) begin bad++; $display("FAIL hold_count got=%0d exp=%0d", ek.size(), mk.size()); end
    total++;
    if (lost_t - sg[$] < TO || lost_t - sg[$] > TO + 4) begin
      bad++; $display("FAIL hold_lost_time got=%0d exp=%0d..%0d", lost_t - sg[$], TO, TO + 4);
    end
    total++; if (gps_lost !== 1'b1) begin bad++; $display("FAIL hold_lost got=%b exp=1", gps_lost); end
    total++; if (int'(compensate) !== xcomp) begin bad++; $display("FAIL hold_comp got=%0d exp=%0d", compensate, xcomp); end
    sg.delete(); sl.delete();
    for (int k = 0; k < 4; k++) begin sg.push_back(10 + k * P); sl.push_back(10 + k * P + 20); end
    play(sg[$] + 20); model();
    total++; if (ek.size() !== mk.size()) begin bad++; $display("FAIL resume_count got=%0d exp=%0d", ek.size(), mk.size()); end
    for (int i = 0; i < mk.size() && i < ek.size(); i++) begin
      total++;
      if (ek[i] !== mk[i] || epe[i] !== mpe[i] || eph[i] !== mph[i] || ecomp[i] !== mcomp[i] || elost[i] !== 0) begin
        bad++; $display("FAIL resume_ev%0d got k=%0d pe=%0d ph=%0d comp=%0d lost=%0d exp k=%0d pe=%0d ph=%0d comp=%0d lost=0",
                        i, ek[i], epe[i], eph[i], ecomp[i], elost[i], mk[i], mpe[i], mph[i], mcomp[i]);
      end
    end
  endtask

  task automatic test_saturate();
    sg.delete(); sl.delete();
    sg = '{12, 1012, 2012, 3057};
    sl = '{982, 1982, 2982};
    to_idle(); play(sg[$] + 20); model();
    total++; if (ek.size() !== mk.size()) begin bad++; $display("FAIL sat_count got=%0d exp=%0d", ek.size(), mk.size()); end
    for (int i = 0; i < mk.size() && i < ek.size(); i++) begin
      total++;
      if (ek[i] !== mk[i] || epe[i] !== mpe[i] || eph[i] !== mph[i] || ecomp[i] !== mcomp[i]) begin
        bad++; $display("FAIL sat_ev%0d got k=%0d pe=%0d ph=%0d comp=%0d exp k=%0d pe=%0d ph=%0d comp=%0d",
                        i, ek[i], epe[i], eph[i], ecomp[i], mk[i], mpe[i], mph[i], mcomp[i]);
      end
    end
    total++; if (compensate !== 25'sd40) begin bad++; $display("FAIL sat_clamp got=%0d exp=40", compensate); end
  endtask

  task automatic test_enable();
    sg = '{10, 1010, 2010};
    sl = '{300, 1300};
    to_idle(); play(sg[$] + TO + 30); model();
    total++; if (ek.size() !== mk.size()) begin bad++; $display("FAIL en_count got=%0d exp=%0d", ek.size(), mk.size()); end
    total++; if (gps_lost !== 1'b1) begin bad++; $display("FAIL en_lost_pre got=%b exp=1", gps_lost); end
    enable = 1'b0;
    repeat (2) @(negedge CLK_SYS);
    total++; if (gps_lost !== 1'b0) begin bad++; $display("FAIL en_lost_clr got=%b exp=0", gps_lost); end
    total++; if (int'(period_err) !== xpe) begin bad++; $display("FAIL en_pe_hold got=%0d exp=%0d", period_err, xpe); end
    sg = '{10, 1010, 2010, 3010};
    sl = '{400, 1400, 2400};
    play(sg[$] + 20);
    total++; if (ek.size() !== 0) begin bad++; $display("FAIL en_off_strobes got=%0d exp=0", ek.size()); end
    enable = 1'b1;
    sg = '{10, 1010, 2010};
    sl = '{1100};
    play(sg[$] + 20); model();
    total++; if (ek.size() !== mk.size()) begin bad++; $display("FAIL en_on_count got=%0d exp=%0d", ek.size(), mk.size()); end
    for (int i = 0; i < mk.size() && i < ek.size(); i++) begin
      total++;
      if (ek[i] !== mk[i] || epe[i] !== mpe[i] || eph[i] !== mph[i] || ecomp[i] !== mcomp[i]) begin
        bad++; $display("FAIL en_ev%0d got k=%0d pe=%0d ph=%0d comp=%0d exp k=%0d pe=%0d ph=%0d comp=%0d",
                        i, ek[i], epe[i], eph[i], ecomp[i], mk[i], mpe[i], mph[i], mcomp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    sg = '{10, 1020, 2030};
    sl = '{510, 1720, 2330};
    to_idle(); play(2600); model();
    total++; if (ek.size() !== mk.size()) begin bad++; $display("FAIL rmid_count got=%0d exp=%0d", ek.size(), mk.size()); end
    CLK_RST = 1'b0;
    #1;
    total++; if (period_err !== 25'sd0) begin bad++; $display("FAIL rmid_pe got=%0d exp=0", period_err); end
    total++; if (phase_err !== 25'sd0) begin bad++; $display("FAIL rmid_ph got=%0d exp=0", phase_err); end
    total++; if (compensate !== 25'sd0) begin bad++; $display("FAIL rmid_comp got=%0d exp=0", compensate); end
    total++; if (meas_valid !== 1'b0 || meas_reject !== 1'b0 || gps_lost !== 1'b0) begin
      bad++; $display("FAIL rmid_flags got=%b%b%b exp=000", meas_valid, meas_reject, gps_lost);
    end
    repeat (3) @(negedge CLK_SYS);
    CLK_RST = 1'b1;
    xpe = 0; xph = 0; xcomp = 0;
    sg = '{10, 1010, 2010};
    sl.delete();
    play(sg[$] + 20); model();
    total++; if (ek.size() !== mk.size()) begin bad++; $display("FAIL rmid_post_count got=%0d exp=%0d", ek.size(), mk.size()); end
    for (int i = 0; i < mk.size() && i < ek.size(); i++) begin
      total++;
      if (ek[i] !== mk[i] || epe[i] !== mpe[i] || eph[i] !== mph[i] || ecomp[i] !== mcomp[i]) begin
        bad++; $display("FAIL rmid_ev%0d got k=%0d pe=%0d ph=%0d comp=%0d exp k=%0d pe=%0d ph=%0d comp=%0d",
                        i, ek[i], epe[i], eph[i], ecomp[i], mk[i], mpe[i], mph[i], mcomp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_coincident();
    test_lag_lead(7);
    test_lag_lead(-5);
    test_reject();
    test_random();
    test_holdover();
    test_saturate();
    test_enable();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
